// File: rtl/isp_loader_pkg.sv
// Shared definitions for the ISP program loader: FSM states, framing constants.
// ISP_LOADER_CHECKSUM_EN adds the CSUM state used for the trailing checksum byte.
package isp_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_FLUSH,
`ifdef ISP_LOADER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_START,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
   localparam int unsigned BYTES_PER_WORD = 4;

   // States in which the loader offers rx_ready.
   function automatic logic accepts_bytes(input state_t s);
      case (s)
         ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_ERR: accepts_bytes = 1'b1;
`ifdef ISP_LOADER_CHECKSUM_EN
         ST_CSUM: accepts_bytes = 1'b1;
`endif
         default: accepts_bytes = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/isp_word_assembler.sv
// Little-endian byte-to-word assembler: byte index counter plus a 3-byte shift register;
// word_valid_o fires combinationally with the 4th byte so the caller can register it.
module isp_word_assembler
   import isp_loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q;
   logic [23:0] asm_q;

   // Shifting right leaves byte 0 in the low bits once three bytes are in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
         asm_q <= '0;
      end else if (clear_i) begin
         idx_q <= '0;
         asm_q <= '0;
      end else if (byte_valid_i) begin
         idx_q <= idx_q + 2'd1;
         asm_q <= {byte_i, asm_q[23:8]};
      end
   end

   always_comb begin
      word_valid_o = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));
      word_o       = {byte_i, asm_q};
   end

endmodule

// File: rtl/isp_program_loader.sv
// Framed byte-stream ISP loader: sync, length, N little-endian words, optional checksum.
// Define ISP_LOADER_CHECKSUM_EN to require the trailing XOR checksum byte.
module isp_program_loader
   import isp_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_BITS  = 12,
   parameter logic [19:0] ENTRY_ADDRESS = 20'h00000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic                    isp_write,
   output logic [ADDRESS_BITS-1:0] isp_address,
   output logic [DATA_WIDTH-1:0]   isp_data,
   output logic                    core_hold,
   output logic                    start,
   output logic [19:0]             prog_address,
   output logic                    done,
   output logic                    error,
   output logic [ADDRESS_BITS:0]   words_loaded
);

   localparam logic [ADDRESS_BITS:0] CNT_ONE = {{ADDRESS_BITS{1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic                    rx_ready_q, isp_write_q, core_hold_q, start_q, done_q, error_q;
   logic [ADDRESS_BITS-1:0] isp_address_q;
   logic [DATA_WIDTH-1:0]   isp_data_q;
   logic [19:0]             prog_address_q;
   logic [ADDRESS_BITS:0]   words_loaded_q, wcnt_q, len_q;
   logic [7:0]              len_lo_q;
`ifdef ISP_LOADER_CHECKSUM_EN
   logic [7:0]              csum_q;
`endif

   logic        hs, sync_hit, len_bad, last_word, word_valid;
   logic [15:0] len_full;
   logic [31:0] word;

   always_comb begin
      hs        = rx_valid && rx_ready_q;
      sync_hit  = hs && (state_q == ST_IDLE || state_q == ST_ERR) && (rx_data == SYNC_BYTE);
      len_full  = {rx_data, len_lo_q};
      len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > 17'(2 ** ADDRESS_BITS));
      last_word = (wcnt_q + CNT_ONE) == len_q;
   end

   isp_word_assembler u_asm (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (sync_hit),
      .byte_valid_i (hs && state_q == ST_DATA),
      .byte_i       (rx_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ERR: if (sync_hit) state_d = ST_LEN_LO;
         ST_LEN_LO:       if (hs) state_d = ST_LEN_HI;
         ST_LEN_HI:       if (hs) state_d = len_bad ? ST_ERR : ST_DATA;
         ST_DATA: begin
            if (word_valid && last_word) begin
`ifdef ISP_LOADER_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_FLUSH;
`endif
            end
         end
         ST_FLUSH:        state_d = ST_START;
`ifdef ISP_LOADER_CHECKSUM_EN
         ST_CSUM:         if (hs) state_d = (rx_data == csum_q) ? ST_START : ST_ERR;
`endif
         ST_START:        state_d = ST_DONE;
         ST_DONE:         state_d = ST_DONE;
         default:         state_d = ST_IDLE;
      endcase
   end

   // Status outputs are decoded from state_d so they line up with the state they describe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rx_ready_q     <= 1'b0;
         isp_write_q    <= 1'b0;
         isp_address_q  <= '0;
         isp_data_q     <= '0;
         core_hold_q    <= 1'b1;
         start_q        <= 1'b0;
         prog_address_q <= '0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         words_loaded_q <= '0;
         wcnt_q         <= '0;
         len_q          <= '0;
         len_lo_q       <= '0;
`ifdef ISP_LOADER_CHECKSUM_EN
         csum_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         rx_ready_q     <= accepts_bytes(state_d);
         isp_write_q    <= word_valid;
         start_q        <= (state_d == ST_START);
         prog_address_q <= (state_d == ST_START) ? ENTRY_ADDRESS : '0;
         done_q         <= (state_d == ST_DONE);
         error_q        <= (state_d == ST_ERR);
         core_hold_q    <= !(state_d == ST_START || state_d == ST_DONE);

         if (hs && state_q == ST_LEN_LO) len_lo_q <= rx_data;
         if (hs && state_q == ST_LEN_HI) len_q    <= len_full[ADDRESS_BITS:0];
         if (word_valid) begin
            isp_data_q    <= word;
            isp_address_q <= wcnt_q[ADDRESS_BITS-1:0];
            wcnt_q        <= wcnt_q + CNT_ONE;
         end
         if (isp_write_q) words_loaded_q <= words_loaded_q + CNT_ONE;
`ifdef ISP_LOADER_CHECKSUM_EN
         if (hs && (state_q == ST_LEN_LO || state_q == ST_LEN_HI || state_q == ST_DATA))
            csum_q <= csum_q ^ rx_data;
`endif
         if (sync_hit) begin
            wcnt_q         <= '0;
            words_loaded_q <= '0;
`ifdef ISP_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
         end
      end
   end

   always_comb begin
      rx_ready     = rx_ready_q;
      isp_write    = isp_write_q;
      isp_address  = isp_address_q;
      isp_data     = isp_data_q;
      core_hold    = core_hold_q;
      start        = start_q;
      prog_address = prog_address_q;
      done         = done_q;
      error        = error_q;
      words_loaded = words_loaded_q;
   end

endmodule

// File: tb/tb_isp_program_loader.sv
// Directed bench for isp_program_loader: frame vector table plus timing, backpressure,
// length-limit, reset-abort and (with ISP_LOADER_CHECKSUM_EN) checksum sequences.
module tb_isp_program_loader;

   localparam int unsigned AB = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready, isp_write, core_hold, start, done, error;
   logic [AB-1:0] isp_address;
   logic [31:0]   isp_data;
   logic [19:0]   prog_address;
   logic [AB:0]   words_loaded;

   isp_program_loader #(.DATA_WIDTH(32), .ADDRESS_BITS(AB), .ENTRY_ADDRESS(20'h00000)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .isp_write    (isp_write),
      .isp_address  (isp_address),
      .isp_data     (isp_data),
      .core_hold    (core_hold),
      .start        (start),
      .prog_address (prog_address),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   typedef struct {
      int           n;      // bytes in the frame (excluding checksum)
      logic [127:0] bytes;  // frame bytes, first byte in the top octet
      int           cfrom;  // first byte covered by the checksum, -1 if the frame is rejected
      int           nw;
      logic [31:0]  w0;
      logic [31:0]  w1;
      bit           dn;
      bit           er;
   } vec_t;

   vec_t vecs[6];

   int checks = 0;
   int failures = 0;

   logic [AB-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int starts = 0, overlap = 0, start_bad = 0, wr_with_rx = 0;

   always @(negedge clock) begin
      if (isp_write) begin
         wr_addr.push_back(isp_address);
         wr_data.push_back(isp_data);
         if (rx_ready && rx_valid) wr_with_rx++;
      end
      if (isp_write && start) overlap++;
      if (start) begin
         starts++;
         if (prog_address !== 20'h00000 || core_hold !== 1'b0) start_bad++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      starts = 0; overlap = 0; start_bad = 0; wr_with_rx = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      @(posedge clock); #1;
      clear_mon();
      @(negedge clock) reset = 1'b0;
      @(posedge clock); #1;
   endtask

   function automatic logic [7:0] vbyte(input vec_t v, input int i);
      return v.bytes[127-8*i -: 8];
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got = 0;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      rx_data = b; rx_valid = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clock);
         if (rx_ready) begin
            @(posedge clock); #1;
            got = 1;
         end
      end
      rx_valid = 1'b0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL handshake_timeout: byte 0x%0h not accepted, required acceptance", b);
      end
   endtask

   task automatic send_bytes(input vec_t v, input int first, input int last, input int gapmax);
      for (int i = first; i <= last; i++)
         send_byte(vbyte(v, i), gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
   endtask

   task automatic send_csum(input vec_t v, input logic [7:0] flip);
`ifdef ISP_LOADER_CHECKSUM_EN
      logic [7:0] c = 8'h00;
      if (v.cfrom >= 0) begin
         for (int i = v.cfrom; i < v.n; i++) c ^= vbyte(v, i);
         send_byte(c ^ flip, 0);
      end
`else
      if (v.cfrom < -1) send_byte(flip, 0);
`endif
   endtask

   task automatic settle();
      repeat (6) @(posedge clock);
      #1;
   endtask

   task automatic check_vec(input int k, input vec_t v);
      check($sformatf("v%0d nwrites", k), wr_data.size(), v.nw);
      for (int i = 0; i < v.nw && i < wr_data.size(); i++) begin
         check($sformatf("v%0d addr%0d", k, i), 32'(wr_addr[i]), i);
         check($sformatf("v%0d data%0d", k, i), wr_data[i], (i == 0) ? v.w0 : v.w1);
      end
      check($sformatf("v%0d done", k), done, v.dn);
      check($sformatf("v%0d error", k), error, v.er);
      check($sformatf("v%0d core_hold", k), core_hold, !v.dn);
      check($sformatf("v%0d starts", k), starts, v.dn ? 1 : 0);
      check($sformatf("v%0d words_loaded", k), 32'(words_loaded), v.nw);
      check($sformatf("v%0d write_start_overlap", k), overlap, 0);
      check($sformatf("v%0d start_outputs", k), start_bad, 0);
   endtask

   initial begin
      vecs[0] = '{n:11, bytes:128'hA5_02_00_13_05_50_00_93_55_15_40_00_00_00_00_00, cfrom:1,
                  nw:2, w0:32'h00500513, w1:32'h40155593, dn:1, er:0};
      vecs[1] = '{n:14, bytes:128'h00_FF_5A_A5_02_00_13_05_50_00_93_55_15_40_00_00, cfrom:4,
                  nw:2, w0:32'h00500513, w1:32'h40155593, dn:1, er:0};
      vecs[2] = '{n:3, bytes:128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, cfrom:-1,
                  nw:0, w0:32'h0, w1:32'h0, dn:0, er:1};
      vecs[3] = '{n:3, bytes:128'hA5_01_10_00_00_00_00_00_00_00_00_00_00_00_00_00, cfrom:-1,
                  nw:0, w0:32'h0, w1:32'h0, dn:0, er:1};
      vecs[4] = '{n:7, bytes:128'hA5_01_00_78_56_34_12_00_00_00_00_00_00_00_00_00, cfrom:1,
                  nw:1, w0:32'h12345678, w1:32'h0, dn:1, er:0};
      vecs[5] = '{n:10, bytes:128'hA5_00_00_A5_01_00_EF_BE_AD_DE_00_00_00_00_00_00, cfrom:4,
                  nw:1, w0:32'hDEADBEEF, w1:32'h0, dn:1, er:0};

      // Reset values while reset is held
      repeat (2) @(posedge clock);
      #1;
      check("rst rx_ready", rx_ready, 0);
      check("rst core_hold", core_hold, 1);
      check("rst isp_write", isp_write, 0);
      check("rst isp_address", 32'(isp_address), 0);
      check("rst isp_data", isp_data, 0);
      check("rst start", start, 0);
      check("rst prog_address", 32'(prog_address), 0);
      check("rst done", done, 0);
      check("rst error", error, 0);
      check("rst words_loaded", 32'(words_loaded), 0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock); #1;
      check("idle rx_ready", rx_ready, 1);

      for (int k = 0; k < 6; k++) begin
         do_reset();
         send_bytes(vecs[k], 0, vecs[k].n - 1, 0);
         send_csum(vecs[k], 8'h00);
         settle();
         check_vec(k, vecs[k]);
      end

      // Completion timing and acceptance during the first write
      do_reset();
      send_bytes(vecs[0], 0, vecs[0].n - 1, 0);
      check("t1 isp_write", isp_write, 1);
      check("t1 isp_address", 32'(isp_address), 1);
      check("t1 start", start, 0);
      @(posedge clock); #1;
`ifdef ISP_LOADER_CHECKSUM_EN
      check("t2 held_for_csum", {isp_write, start, core_hold, rx_ready}, 4'b0011);
      send_csum(vecs[0], 8'h00);
      check("u1 start", start, 1);
      check("u1 core_hold", core_hold, 0);
      check("u1 error", error, 0);
`else
      check("t2 isp_write", isp_write, 0);
      check("t2 start", start, 1);
      check("t2 core_hold", core_hold, 0);
      check("t2 rx_ready", rx_ready, 0);
`endif
      @(posedge clock); #1;
      check("t3 done", done, 1);
      check("t3 start", start, 0);
      check("b2b write_with_rx", wr_with_rx, 1);

      // Random gaps on rx_valid
      do_reset();
      send_bytes(vecs[0], 0, vecs[0].n - 1, 3);
      send_csum(vecs[0], 8'h00);
      settle();
      check_vec(10, vecs[0]);

      // N == 2^ADDRESS_BITS is the largest accepted length
      do_reset();
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
      @(posedge clock); #1;
      check("n4096 error", error, 0);
      check("n4096 rx_ready", rx_ready, 1);
      check("n4096 core_hold", core_hold, 1);

      // Reset after 5 data bytes: one word already written, nothing started
      do_reset();
      send_bytes(vecs[0], 0, 7, 0);
      repeat (2) @(posedge clock);
      #1;
      check("abort pre isp_data", isp_data, 32'h00500513);
      #2 reset = 1'b1;
      #1;
      check("abort rx_ready", rx_ready, 0);
      check("abort core_hold", core_hold, 1);
      check("abort isp_data", isp_data, 0);
      check("abort words_loaded", 32'(words_loaded), 0);
      check("abort start_done", {start, done, isp_write}, 3'b000);
      check("abort starts", starts, 0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock); #1;
      clear_mon();
      send_bytes(vecs[0], 0, vecs[0].n - 1, 0);
      send_csum(vecs[0], 8'h00);
      settle();
      check_vec(11, vecs[0]);

`ifdef ISP_LOADER_CHECKSUM_EN
      // Bad checksum: error next cycle, no start; a good frame then recovers
      do_reset();
      send_bytes(vecs[0], 0, vecs[0].n - 1, 0);
      send_csum(vecs[0], 8'hFF);
      check("csum_bad error", error, 1);
      check("csum_bad start", start, 0);
      check("csum_bad core_hold", core_hold, 1);
      settle();
      check("csum_bad starts", starts, 0);
      clear_mon();
      send_bytes(vecs[0], 0, vecs[0].n - 1, 0);
      send_csum(vecs[0], 8'h00);
      settle();
      check_vec(12, vecs[0]);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
